// File: rtl/pbit_field_sequencer.sv
// Pipelined p-bit local-field sequencer: two multiply stages, then a LANES-wide sweep
// over the free bits of the selected factor, saturating each field into a probability code.
module pbit_field_sequencer #(
  parameter int MAX_N_DIGIT = 64,
  parameter int LANES       = 4,
  parameter int FRAC        = 4,
  parameter int OUT_W       = 8
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   mode,
  input  logic [MAX_N_DIGIT/2-1:0]               X,
  input  logic [MAX_N_DIGIT/2-1:0]               Y,
  input  logic [MAX_N_DIGIT-1:0]                 N,
  input  logic [1:0]                             energy_shift,
  input  logic [6:0]                             N_digit,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [(MAX_N_DIGIT/2-1)*OUT_W-1:0]     pbit_in,
  output logic [$clog2(MAX_N_DIGIT/2)-1:0]       sat_count,
  output logic                                   busy
);

  localparam int H   = MAX_N_DIGIT / 2;
  localparam int NB  = H - 1;
  localparam int C   = (NB + LANES - 1) / LANES;
  localparam int GW  = (C > 1) ? $clog2(C) : 1;
  localparam int BW  = $clog2(2 * H);
  localparam int RW  = MAX_N_DIGIT + 1;
  localparam int QW  = RW + H + 1;
  localparam int IW  = 2 * MAX_N_DIGIT + 8;
  localparam int SCW = $clog2(H);
  localparam int PBW = NB * OUT_W;

  localparam logic signed [IW-1:0] CODE_MID = IW'(2 ** (OUT_W - 1));
  localparam logic signed [IW-1:0] CODE_MAX = IW'(2 ** OUT_W - 1);

  typedef enum logic [2:0] {S_IDLE, S_MUL1, S_MUL2, S_SWEEP, S_DONE} state_t;

  state_t state_q, state_d;

  logic                    mode_q;
  logic [H-1:0]            x_q, y_q;
  logic [MAX_N_DIGIT-1:0]  n_q;
  logic [1:0]              shift_q;
  logic [6:0]              ndig_q;
  logic [2*H-1:0]          p_q;
  logic signed [QW-1:0]    q_q;
  logic [2*H-1:0]          v2_q;
  logic [GW-1:0]           g_q;
  logic [PBW-1:0]          pbit_q;
  logic [SCW-1:0]          sat_q;

  logic [H-1:0]            u, v;
  logic                    accept, sweep_last;
  logic [6:0]              ndig_eff;
  logic [8:0]              shift_amt;
  logic [RW-1:0]           r_val;
  logic signed [QW-1:0]    r_ext, v_sext;
  logic signed [IW-1:0]    q_ext, v2_ext, q_term, v_term, field, diff;

  logic [BW-1:0]           lane_bit  [LANES];
  logic                    lane_on   [LANES];
  logic                    lane_sat  [LANES];
  logic [OUT_W-1:0]        lane_code [LANES];
  logic [SCW-1:0]          sat_sum;

  assign u          = mode_q ? y_q : x_q;
  assign v          = mode_q ? x_q : y_q;
  assign accept     = in_valid && (state_q == S_IDLE);
  assign sweep_last = (g_q == GW'(C - 1));

  assign ndig_eff  = (ndig_q < 7'd4) ? 7'd4 : ndig_q;
  assign shift_amt = {1'b0, ndig_eff, 1'b0} - 9'(FRAC) - {7'b0, shift_q};

  assign r_val  = {1'b0, n_q} - {1'b0, p_q};
  assign r_ext  = {{(QW-RW){r_val[RW-1]}}, r_val};
  assign v_sext = {{(QW-H){1'b0}}, v};
  assign q_ext  = {{(IW-QW){q_q[QW-1]}}, q_q};
  assign v2_ext = {{(IW-2*H){1'b0}}, v2_q};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (in_valid) state_d = S_MUL1;
      S_MUL1:  state_d = S_MUL2;
      S_MUL2:  state_d = S_SWEEP;
      S_SWEEP: if (sweep_last) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One field unit per lane; temporaries are fully rewritten on every iteration.
  always_comb begin
    sat_sum = '0;
    q_term  = '0;
    v_term  = '0;
    field   = '0;
    diff    = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_bit[l] = BW'(1 + int'(g_q) * LANES + l);
      lane_on[l]  = (lane_bit[l] <= BW'(NB));
      q_term      = q_ext <<< (lane_bit[l] + 4);
      v_term      = v2_ext <<< (2 * lane_bit[l] + 3);
      field       = u[lane_bit[l][SCW-1:0]] ? (q_term + v_term) : (q_term - v_term);
      field       = field >>> shift_amt;
      diff        = CODE_MID - field;
      if (diff < 0) begin
        lane_code[l] = '0;
        lane_sat[l]  = 1'b1;
      end else if (diff > CODE_MAX) begin
        lane_code[l] = '1;
        lane_sat[l]  = 1'b1;
      end else begin
        lane_code[l] = diff[OUT_W-1:0];
        lane_sat[l]  = 1'b0;
      end
      if (lane_on[l] && lane_sat[l]) sat_sum = sat_sum + SCW'(1);
    end
  end

  // NOTE: sequential state uses <= so every register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pbit_q  <= '0;
      sat_q   <= '0;
      g_q     <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      n_q     <= '0;
      shift_q <= '0;
      ndig_q  <= '0;
      p_q     <= '0;
      q_q     <= '0;
      v2_q    <= '0;
    end else begin
      if (accept) begin
        mode_q  <= mode;
        x_q     <= X;
        y_q     <= Y;
        n_q     <= N;
        shift_q <= energy_shift;
        ndig_q  <= N_digit;
        sat_q   <= '0;
      end
      unique case (state_q)
        S_MUL1: p_q <= (2*H)'(u) * (2*H)'(v);
        S_MUL2: begin
          q_q  <= r_ext * v_sext;
          v2_q <= (2*H)'(v) * (2*H)'(v);
          g_q  <= '0;
        end
        S_SWEEP: begin
          g_q   <= g_q + GW'(1);
          sat_q <= sat_q + sat_sum;
          for (int l = 0; l < LANES; l++) begin
            if (lane_on[l]) pbit_q[(lane_bit[l] - 1) * OUT_W +: OUT_W] <= lane_code[l];
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign pbit_in   = pbit_q;
  assign sat_count = sat_q;

endmodule

// File: doc/pbit_field_sequencer.md
# pbit_field_sequencer

Parametrised, pipelined successor of the combinational p-bit energy calculator. Computes the signed local field of every free bit (bit 1..H-1, H = MAX_N_DIGIT/2) of the selected factor (X or Y) from the operands N, X and Y. Each field is saturated into an unsigned OUT_W-bit p-bit probability code. It sits between the factor registers and the p-bit array, and is time-multiplexed over LANES field units with valid/ready handshakes on both sides.

## Interface
- MAX_N_DIGIT, 64, maximum bit width of N; H = MAX_N_DIGIT/2 is the factor width.
- LANES, 4, number of fields computed per sweep cycle (1..H-1).
- FRAC, 4, fractional bits of the field before encoding.
- OUT_W, 8, width of each p-bit code.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- mode  in  1  0: update X (V=Y, U=X); 1: update Y (V=X, U=Y).
- X, Y  in  H each  current factors.
- N  in  MAX_N_DIGIT  number to factor.
- energy_shift  in  2  temperature shift.
- N_digit  in  7  active bit length of N; values below 4 are treated as 4.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer accepts the result.
- pbit_in  out  (H-1)*OUT_W  code for bit b at slice [(b-1)*OUT_W +: OUT_W].
- sat_count  out  $clog2(H)  number of fields clamped in the last result.
- busy  out  1  state is not IDLE.

## Operation
- The request is captured when in_valid && in_ready. mode, X, Y, N, energy_shift and N_digit are registered, so inputs may change afterwards.
- States and transitions:
  - IDLE -> MUL1 on accept.
  - MUL1 -> MUL2.
  - MUL2 -> SWEEP.
  - SWEEP lasts C = ceil((H-1)/LANES) cycles, then -> DONE.
  - DONE -> IDLE on out_ready.
- MUL1 computes P = U*V (full width).
- MUL2 computes R = N - P (signed, MAX_N_DIGIT+1 bits), Q = R*V and V2 = V*V.
- SWEEP cycle g handles bits b = 1 + g*LANES + l for l in 0..LANES-1. Lanes with b > H-1 are ignored.
- Field: F_b = (Q*2^(b+4) + s*V2*2^(2b+3)) >>> S.
  - s = +1 if U[b] = 1, else -1.
  - S = 2*N_digit - FRAC - energy_shift.
  - Computed at full precision with no intermediate truncation (internal signed width 2*MAX_N_DIGIT+8). >>> is arithmetic, so it rounds toward minus infinity.
- Encoding: code = clamp(2^(OUT_W-1) - F_b, 0, 2^OUT_W - 1). A field is counted in sat_count when the clamp engages.
- pbit_in slices update lane-by-lane during SWEEP. Their contents are guaranteed only while out_valid is high.

## Timing
- Reset values: state IDLE, in_ready 1, out_valid 0, busy 0, pbit_in all 0, sat_count 0.
- With accept at cycle 0:
  - MUL1 at cycle 1, MUL2 at cycle 2, SWEEP at cycles 3..2+C.
  - out_valid rises at cycle 3+C (11 with default parameters).
- out_valid, pbit_in and sat_count hold stable while out_ready is low, for any duration.
- The transfer completes in the cycle where out_valid && out_ready. The next cycle is IDLE with in_ready 1, out_valid 0 and pbit_in retained. There is no back-to-back accept in the DONE cycle.
- in_valid is ignored while in_ready is low. The request is not queued.
- rst asserted in any state, including mid-SWEEP: the next cycle returns to the reset values, and the partial result is discarded.
- rst takes priority over a simultaneous accept or transfer.

## Test plan
- Basic X update (defaults): N=15, X=3, Y=5, mode 0, N_digit 4, shift 0 (S=4, R=0).
  - Required: code[b=1] = 78 (F=+50).
  - Required: code[b>=2] = 255 (F=-200, -800, ...).
  - Required: sat_count = 30; out_valid at cycle 11.
- Mode swap: same operands with mode 1 (U=Y=5, V=3, V2=9).
  - Required: F_1 = -9*32>>>4 = -18, code 146.
  - Required: F_2 = +9*128>>>4 = 72, code 56.
- Rounding and shift: choose operands and shift so that F_b = -2.5 before the shift.
  - Required: code = 131 (floor to -3).
  - Required: raising energy_shift by 1 doubles |F_b| before clamp.
- Backpressure: hold out_ready low for 5 cycles after out_valid.
  - Required: outputs stable, in_ready 0, in_valid pulses ignored.
  - Required: on release, IDLE with in_ready 1 the next cycle.
- Reset mid-sweep: assert rst at cycle 5.
  - Required: next cycle out_valid 0, pbit_in 0, sat_count 0, in_ready 1.
  - Required: a new request then completes normally.
- Parameter sweep: LANES = 1 and LANES = 31 with identical stimulus.
  - Required: identical pbit_in and sat_count.
  - Required: out_valid at cycles 34 and 4 respectively.
